acc_seq_ctrl: RTL

- Sequencer that drives the convolution accelerator wrapper (data buffer, filter buffer, conv core, output FIFO) on behalf of the CPU.
- On a start command it:
  - streams DATA_WORDS input words, then FILT_WORDS filter words, from system memory into the accelerator's write port;
  - waits a programmed compute interval;
  - drains RES_WORDS 64-bit results from the accelerator output FIFO;
  - writes each result back to memory as two 32-bit words.
- Sits between the CPU-mapped command registers, the memory bus and the accelerator.

---
 rtl/acc_seq_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/acc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acc_seq_ctrl
//
// Drives the convolution accelerator on behalf of the CPU.  After a start
// command it copies DATA_WORDS input words and FILT_WORDS filter words from
// system memory into the accelerator write port, lets the accelerator run
// for WAIT_CYC cycles, then pops RES_WORDS 64-bit results from the
// accelerator output FIFO and writes each one back to memory as two
// 32-bit words (low word first).
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   start           one-cycle command pulse, honoured only while idle
//   src_addr        byte address of the input block (data then filter)
//   dst_addr        byte address of the result block
//   busy            high while a command is in progress
//   done            one-cycle pulse when the last result word is written
//   mem_req/mem_we/mem_addr/mem_wdata   memory request, held until mem_gnt
//   mem_gnt         memory accepted the request this cycle
//   mem_rvalid/mem_rdata                memory read return
//   acc_addr/acc_en_w/acc_data_in       accelerator write port
//   acc_en_r        accelerator output-FIFO pop strobe
//   acc_data_out    accelerator output-FIFO data, valid RD_LAT after a pop
// ---------------------------------------------------------------------------
module acc_seq_ctrl #(
   parameter int DATA_WORDS = 12,
   parameter int FILT_WORDS = 3,
   parameter int FILT_BASE  = 64,
   parameter int RES_WORDS  = 4,
   parameter int WAIT_CYC   = 32,
   parameter int RD_LAT     = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] acc_addr,
   output logic        acc_en_w,
   output logic [31:0] acc_data_in,
   output logic        acc_en_r,
   input  logic [63:0] acc_data_out
);

   localparam logic [31:0] TOT_WORDS  = 32'(DATA_WORDS + FILT_WORDS);
   localparam logic [31:0] DATA_LIM   = 32'(DATA_WORDS);
   localparam logic [31:0] FILT_OFS   = 32'(FILT_BASE);
   localparam logic [31:0] RES_LIM    = 32'(RES_WORDS);
   localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYC - 1);
   localparam logic [31:0] RDLAT_LAST = 32'(RD_LAT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LD_REQ,
      S_LD_WAIT,
      S_LD_WR,
      S_WAIT,
      S_RD_POP,
      S_RD_CAP,
      S_WR_LO,
      S_WR_HI,
      S_FIN
   } state_t;

   state_t      state;
   logic [31:0] src_q;      // latched source block address
   logic [31:0] dst_q;      // latched destination block address
   logic [31:0] word_idx;   // load-loop word index i
   logic [31:0] res_idx;    // result index k
   logic [31:0] cyc_cnt;    // shared WAIT / RD_CAP cycle counter
   logic [63:0] result_q;   // captured accelerator result

   // Next-word values used when leaving LD_WR.
   logic [31:0] word_nxt;
   logic [31:0] res_nxt;

   assign word_nxt = word_idx + 32'd1;
   assign res_nxt  = res_idx + 32'd1;

   // Every output is a register: each transition loads the values the
   // destination state must present, so they are glitch-free and stay
   // stable across memory stalls without extra holding logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         word_idx    <= '0;
         res_idx     <= '0;
         cyc_cnt     <= '0;
         result_q    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         acc_addr    <= '0;
         acc_en_w    <= 1'b0;
         acc_data_in <= '0;
         acc_en_r    <= 1'b0;
      end else begin
         // Single-cycle strobes default low.
         done     <= 1'b0;
         acc_en_w <= 1'b0;
         acc_en_r <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  src_q    <= src_addr;
                  dst_q    <= dst_addr;
                  word_idx <= '0;
                  res_idx  <= '0;
                  busy     <= 1'b1;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= src_addr;
                  state    <= S_LD_REQ;
               end
            end

            S_LD_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= S_LD_WAIT;
               end
            end

            // Only one read is ever outstanding, so the first rvalid seen
            // here belongs to the current word.
            S_LD_WAIT: begin
               if (mem_rvalid) begin
                  acc_en_w    <= 1'b1;
                  acc_data_in <= mem_rdata;
                  if (word_idx < DATA_LIM)
                     acc_addr <= word_idx;
                  else
                     acc_addr <= FILT_OFS + (word_idx - DATA_LIM);
                  state <= S_LD_WR;
               end
            end

            S_LD_WR: begin
               word_idx <= word_nxt;
               if (word_nxt < TOT_WORDS) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= src_q + {word_nxt[29:0], 2'b00};
                  state    <= S_LD_REQ;
               end else begin
                  cyc_cnt <= '0;
                  state   <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (cyc_cnt == WAIT_LAST) begin
                  cyc_cnt  <= '0;
                  res_idx  <= '0;
                  acc_en_r <= 1'b1;
                  state    <= S_RD_POP;
               end else begin
                  cyc_cnt <= cyc_cnt + 32'd1;
               end
            end

            S_RD_POP: begin
               cyc_cnt <= '0;
               state   <= S_RD_CAP;
            end

            // RD_CAP lasts RD_LAT cycles; the FIFO data is valid in the last
            // of them and is forwarded straight into the low-word write.
            S_RD_CAP: begin
               if (cyc_cnt == RDLAT_LAST) begin
                  result_q  <= acc_data_out;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= dst_q + {res_idx[28:0], 3'b000};
                  mem_wdata <= acc_data_out[31:0];
                  state     <= S_WR_LO;
               end else begin
                  cyc_cnt <= cyc_cnt + 32'd1;
               end
            end

            // The high-word request follows the low word back-to-back.
            S_WR_LO: begin
               if (mem_gnt) begin
                  mem_addr  <= dst_q + {res_idx[28:0], 3'b000} + 32'd4;
                  mem_wdata <= result_q[63:32];
                  state     <= S_WR_HI;
               end
            end

            S_WR_HI: begin
               if (mem_gnt) begin
                  res_idx <= res_nxt;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (res_nxt < RES_LIM) begin
                     acc_en_r <= 1'b1;
                     state    <= S_RD_POP;
                  end else begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end
            end

            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
